// File: rtl/rr_arbiter_param_if.sv
// Request/grant bundle shared by the bus masters and the round-robin arbiter.
interface rr_arbiter_param_if #(
    parameter int N   = 4,
    parameter int IDW = 2
);
    logic [N-1:0]   req;
    logic [N-1:0]   lock;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;

    modport master (
        output req,
        output lock,
        input  grant,
        input  grant_valid,
        input  grant_id
    );

    modport slave (
        input  req,
        input  lock,
        output grant,
        output grant_valid,
        output grant_id
    );
endinterface

// File: rtl/rr_arbiter_param.sv
// N-way round-robin arbiter: registered one-hot grant plus encoded index,
// with an owner lock that can hold the grant for at most MAX_HOLD cycles.
module rr_arbiter_param #(
    parameter int N        = 4,
    parameter int IDW      = 2,
    parameter int MAX_HOLD = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    rr_arbiter_param_if.slave     bus
);
    localparam int unsigned NU  = N;
    localparam int unsigned HCW = $clog2(MAX_HOLD) + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        OWNED = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [IDW-1:0]  ptr_q, ptr_d;
    logic [HCW-1:0]  hold_q, hold_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IDW-1:0]  id_q, id_d;
    logic            valid_q, valid_d;

    logic            keep;
    logic            found;
    logic [IDW-1:0]  hit;
    int unsigned     idx;

    // State register: ptr resets to N-1 so requester 0 is searched first.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= IDW'(N - 1);
            hold_q  <= '0;
            grant_q <= '0;
            id_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            grant_q <= grant_d;
            id_q    <= id_d;
            valid_q <= valid_d;
        end
    end

    // Next state: keep a locked owner while its budget lasts, else rotate from ptr+1.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        grant_d = grant_q;
        id_d    = id_q;
        valid_d = valid_q;
        found   = 1'b0;
        hit     = '0;
        idx     = 0;

        for (int unsigned k = 1; k <= NU; k++) begin
            idx = 32'(ptr_q) + k;
            if (idx >= NU) idx = idx - NU;
            if (!found && bus.req[IDW'(idx)]) begin
                found = 1'b1;
                hit   = IDW'(idx);
            end
        end

        keep = (state_q == OWNED) && bus.req[ptr_q] && bus.lock[ptr_q] &&
               (hold_q < HCW'(MAX_HOLD - 1));

        if (keep) begin
            hold_d = hold_q + HCW'(1);
        end else if (found) begin
            state_d      = OWNED;
            ptr_d        = hit;
            hold_d       = '0;
            grant_d      = '0;
            grant_d[hit] = 1'b1;
            id_d         = hit;
            valid_d      = 1'b1;
        end else begin
            state_d = IDLE;
            hold_d  = '0;
            grant_d = '0;
            id_d    = '0;
            valid_d = 1'b0;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.grant_valid = valid_q;
    assign bus.grant_id    = id_q;
endmodule

// File: tb/tb_rr_arbiter_param.sv
// Directed bench: a 4-way arbiter (MAX_HOLD=4) and a 5-way one (MAX_HOLD=1).
module tb_rr_arbiter_param;
    logic clk;
    logic rst_a;
    logic rst_b;
    int   checks;
    int   errors;
    logic mon_en;

    rr_arbiter_param_if #(.N(4), .IDW(2)) ia ();
    rr_arbiter_param_if #(.N(5), .IDW(3)) ib ();

    rr_arbiter_param #(.N(4), .IDW(2), .MAX_HOLD(4)) dut_a (
        .clk (clk),
        .rst (rst_a),
        .bus (ia.slave)
    );

    rr_arbiter_param #(.N(5), .IDW(3), .MAX_HOLD(1)) dut_b (
        .clk (clk),
        .rst (rst_b),
        .bus (ib.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        rst_a = 1'b1;
        ia.req = 4'b0000;
        ia.lock = 4'b0000;
        step();
        rst_a = 1'b0;
    endtask

    // Output invariants on the 4-way arbiter, sampled on the falling edge.
    always @(negedge clk) begin
        if (mon_en) begin
            logic [1:0] exp_id;
            exp_id = 2'd0;
            for (int i = 0; i < 4; i++) if (ia.grant[i]) exp_id = 2'(i);
            checks++;
            if (!$onehot0(ia.grant) || (ia.grant_valid !== (|ia.grant)) ||
                (ia.grant_id !== exp_id)) begin
                errors++;
                $display("FAIL invariant grant=%b valid=%b id=%0d expected_id=%0d",
                         ia.grant, ia.grant_valid, ia.grant_id, exp_id);
            end
        end
    end

    task automatic test_reset();
        logic [3:0] exp_g [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rst_a = 1'b1;
        ia.req = 4'b1111;
        ia.lock = 4'b0000;
        for (int c = 0; c < 2; c++) begin
            step();
            checks++;
            if (ia.grant !== 4'b0000 || ia.grant_valid !== 1'b0 || ia.grant_id !== 2'd0) begin
                errors++;
                $display("FAIL reset grant=%b valid=%b id=%0d required 0000/0/0",
                         ia.grant, ia.grant_valid, ia.grant_id);
            end
        end
        mon_en = 1'b1;
        rst_a = 1'b0;
        for (int c = 0; c < 5; c++) begin
            step();
            checks++;
            if (ia.grant !== exp_g[c] || ia.grant_id !== 2'(c % 4) || ia.grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL rotate cycle %0d grant=%b id=%0d required %b id %0d",
                         c, ia.grant, ia.grant_id, exp_g[c], c % 4);
            end
        end
    endtask

    task automatic test_single();
        reset_a();
        ia.req = 4'b0100;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (ia.grant !== 4'b0100 || ia.grant_id !== 2'd2 || ia.grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL single cycle %0d grant=%b id=%0d valid=%b required 0100/2/1",
                         c, ia.grant, ia.grant_id, ia.grant_valid);
            end
        end
    endtask

    task automatic test_lock_hold();
        logic [3:0] exp_g [10] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010,
                                   4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
        reset_a();
        ia.req = 4'b0011;
        ia.lock = 4'b0001;
        for (int c = 0; c < 10; c++) begin
            step();
            checks++;
            if (ia.grant !== exp_g[c]) begin
                errors++;
                $display("FAIL lock_hold cycle %0d grant=%b required %b", c, ia.grant, exp_g[c]);
            end
        end
    endtask

    task automatic test_owner_drop();
        logic [3:0] exp_g [6] = '{4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010, 4'b0001};
        reset_a();
        ia.req = 4'b0011;
        ia.lock = 4'b0001;
        step();
        step();
        checks++;
        if (ia.grant !== 4'b0001) begin
            errors++;
            $display("FAIL drop_setup grant=%b required 0001", ia.grant);
        end
        ia.req = 4'b0010;
        step();
        checks++;
        if (ia.grant !== 4'b0010) begin
            errors++;
            $display("FAIL drop_release grant=%b required 0010", ia.grant);
        end
        // Owner 1 starts a fresh hold budget: 3 more held cycles, then back to 0.
        ia.req = 4'b0011;
        ia.lock = 4'b0010;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) ia.lock = 4'b0000;
            step();
            checks++;
            if (ia.grant !== exp_g[c]) begin
                errors++;
                $display("FAIL drop_after cycle %0d grant=%b required %b", c, ia.grant, exp_g[c]);
            end
        end
    endtask

    task automatic test_idle_pointer();
        reset_a();
        ia.req = 4'b0010;
        step();
        checks++;
        if (ia.grant !== 4'b0010 || ia.grant_id !== 2'd1) begin
            errors++;
            $display("FAIL idle_setup grant=%b id=%0d required 0010/1", ia.grant, ia.grant_id);
        end
        ia.req = 4'b0000;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if (ia.grant !== 4'b0000 || ia.grant_valid !== 1'b0 || ia.grant_id !== 2'd0) begin
                errors++;
                $display("FAIL idle cycle %0d grant=%b valid=%b id=%0d required 0000/0/0",
                         c, ia.grant, ia.grant_valid, ia.grant_id);
            end
        end
        ia.req = 4'b0011;
        step();
        checks++;
        if (ia.grant !== 4'b0001 || ia.grant_id !== 2'd0) begin
            errors++;
            $display("FAIL idle_wrap grant=%b id=%0d required 0001/0", ia.grant, ia.grant_id);
        end
    endtask

    task automatic test_non_owner_lock();
        reset_a();
        ia.req = 4'b0011;
        ia.lock = 4'b0010;
        step();
        step();
        checks++;
        if (ia.grant !== 4'b0010) begin
            errors++;
            $display("FAIL non_owner_lock grant=%b required 0010", ia.grant);
        end
        // Lock with req low must not keep the grant.
        ia.req = 4'b0001;
        ia.lock = 4'b0010;
        step();
        checks++;
        if (ia.grant !== 4'b0001) begin
            errors++;
            $display("FAIL lock_no_req grant=%b required 0001", ia.grant);
        end
    endtask

    task automatic test_n5_reset();
        logic [4:0] exp_g [4] = '{5'b00001, 5'b10000, 5'b00001, 5'b10000};
        logic [2:0] exp_i [4] = '{3'd0, 3'd4, 3'd0, 3'd4};
        rst_b = 1'b1;
        ib.req = 5'b10001;
        ib.lock = 5'b11111;
        step();
        checks++;
        if (ib.grant !== 5'b00000) begin
            errors++;
            $display("FAIL n5_reset grant=%b required 00000", ib.grant);
        end
        rst_b = 1'b0;
        for (int c = 0; c < 4; c++) begin
            step();
            checks++;
            if (ib.grant !== exp_g[c] || ib.grant_id !== exp_i[c] || ib.grant_valid !== 1'b1) begin
                errors++;
                $display("FAIL n5_alt cycle %0d grant=%b id=%0d required %b id %0d",
                         c, ib.grant, ib.grant_id, exp_g[c], exp_i[c]);
            end
        end
        rst_b = 1'b1;
        step();
        checks++;
        if (ib.grant !== 5'b00000 || ib.grant_valid !== 1'b0 || ib.grant_id !== 3'd0) begin
            errors++;
            $display("FAIL n5_mid_reset grant=%b valid=%b id=%0d required 00000/0/0",
                     ib.grant, ib.grant_valid, ib.grant_id);
        end
        rst_b = 1'b0;
        step();
        checks++;
        if (ib.grant !== 5'b00001 || ib.grant_id !== 3'd0) begin
            errors++;
            $display("FAIL n5_post_reset grant=%b id=%0d required 00001/0", ib.grant, ib.grant_id);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        mon_en = 1'b0;
        rst_a = 1'b1;
        rst_b = 1'b1;
        ia.req = '0;
        ia.lock = '0;
        ib.req = '0;
        ib.lock = '0;
        test_reset();
        test_single();
        test_lock_hold();
        test_owner_drop();
        test_idle_pointer();
        test_non_owner_lock();
        test_n5_reset();
        mon_en = 1'b0;
        #2;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
